// File: rtl/sim_uart_transmitter.sv
// Simulation UART transmitter: byte FIFO feeding an 8N1-style serialiser
// with optional parity and one or two stop bits, bit period = scaler+1 clocks.
module sim_uart_transmitter #(
  parameter int p_fifo_depth = 16,
  parameter int p_stop_bits  = 1,
  parameter int p_parity     = 0
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic [31:0]                     scaler,
  input  logic [7:0]                      i_data,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic                            o_tx,
  output logic                            o_busy,
  output logic [$clog2(p_fifo_depth):0]   o_fifo_count
);

  localparam int AW = $clog2(p_fifo_depth);
  localparam int CW = AW + 1;
  localparam logic STOP_LAST = (p_stop_bits == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Reset asserts immediately but releases two clocks after rst falls.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) rst_sync_q <= '1;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  logic [7:0]    mem_q [p_fifo_depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [31:0]   baud_q, baud_d;
  logic [31:0]   period_q, period_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign o_ready      = (cnt_q < CW'(p_fifo_depth));
  assign push         = i_valid && o_ready;
  assign bit_end      = (baud_q == '0);
  assign o_busy       = busy_q;
  assign o_fifo_count = cnt_q;

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      baud_q     <= '0;
      period_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      baud_q     <= baud_d;
      period_q   <= period_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    period_d   = period_q;
    pop        = 1'b0;
    baud_d     = bit_end ? period_q : baud_q - 32'd1;

    case (state_q)
      IDLE: begin
        baud_d = baud_q;
        if (cnt_q != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d    = (p_parity != 0) ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            if (cnt_q != '0) pop = 1'b1;
            else             state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop always begins a new frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      state_d  = START;
      shift_d  = mem_q[rd_ptr_q];
      par_d    = ^mem_q[rd_ptr_q];
      period_d = scaler;
      baud_d   = scaler;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    busy_d   = (state_d != IDLE) || (cnt_d != '0);
  end

  // Output logic
  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shift_q[0];
      PARITY:  o_tx = (p_parity == 2) ? ~par_q : par_q;
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sim_uart_transmitter.sv
// Bench for sim_uart_transmitter: three parameter variants share one stimulus
// stream and are checked every cycle against a frame-level reference model.
module tb_sim_uart_transmitter;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;
  logic [31:0] scaler = 32'd3;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;

  logic       rdy_w  [3];
  logic       tx_w   [3];
  logic       busy_w [3];
  logic [4:0] cnt_w  [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk_in = ~clk_in;

  sim_uart_transmitter #(.p_fifo_depth(16), .p_stop_bits(1), .p_parity(0)) u0 (
    .clk_in(clk_in), .rst(rst), .scaler(scaler), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_fifo_count(cnt_w[0]));

  sim_uart_transmitter #(.p_fifo_depth(16), .p_stop_bits(2), .p_parity(1)) u1 (
    .clk_in(clk_in), .rst(rst), .scaler(scaler), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_fifo_count(cnt_w[1]));

  sim_uart_transmitter #(.p_fifo_depth(16), .p_stop_bits(1), .p_parity(2)) u2 (
    .clk_in(clk_in), .rst(rst), .scaler(scaler), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_fifo_count(cnt_w[2]));

  localparam int PAR   [3] = '{0, 1, 2};
  localparam int STOPB [3] = '{1, 2, 1};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a circular buffer, each frame as a list of bit
  // values, with the expected line level found by dividing elapsed cycles.
  logic [7:0] m_buf  [3][32];
  int         m_head [3];
  int         m_cnt  [3];
  bit         m_act  [3];
  longint     m_pos  [3];
  longint     m_per  [3];
  int         m_nb   [3];
  bit         m_bits [3][12];

  always @(posedge clk_in or posedge rst) begin : model
    logic [7:0] b;
    bit pu, en;
    int n;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_head[k] = 0;
        m_cnt[k]  = 0;
        m_act[k]  = 1'b0;
        m_pos[k]  = 0;
        m_per[k]  = 1;
        m_nb[k]   = 10;
      end else begin
        pu = i_valid && (m_cnt[k] < 16);
        en = m_act[k] && (m_pos[k] == m_per[k] * m_nb[k] - 1);
        if (m_act[k] && !en) begin
          m_pos[k]++;
        end else if (m_cnt[k] > 0) begin
          b = m_buf[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % 32;
          m_cnt[k]--;
          m_bits[k][0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[k][1+i] = b[i];
          n = 9;
          if (PAR[k] != 0) begin
            m_bits[k][9] = (PAR[k] == 1) ? ^b : ~^b;
            n = 10;
          end
          for (int s = 0; s < STOPB[k]; s++) begin
            m_bits[k][n] = 1'b1;
            n++;
          end
          m_nb[k]  = n;
          m_act[k] = 1'b1;
          m_pos[k] = 0;
          m_per[k] = longint'(scaler) + 1;
        end else begin
          m_act[k] = 1'b0;
        end
        if (pu) begin
          m_buf[k][(m_head[k] + m_cnt[k]) % 32] = i_data;
          m_cnt[k]++;
        end
      end
    end
  end

  function automatic logic exp_tx(input int k);
    if (!m_act[k]) return 1'b1;
    return m_bits[k][int'(m_pos[k] / m_per[k])];
  endfunction

  always @(negedge clk_in) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("tx[%0d]", k),    64'(tx_w[k]),   64'(exp_tx(k)));
        check($sformatf("busy[%0d]", k),  64'(busy_w[k]), 64'(m_act[k] || (m_cnt[k] != 0)));
        check($sformatf("count[%0d]", k), 64'(cnt_w[k]),  64'(m_cnt[k]));
        check($sformatf("ready[%0d]", k), 64'(rdy_w[k]),  64'(m_cnt[k] < 16));
      end
    end
  end

  // Per-cycle capture, indexed by cycles since the edge that took the first byte.
  logic       rec_tx   [3][128];
  logic       rec_busy [3][128];
  logic [4:0] rec_cnt  [128];
  logic       rec_rdy  [128];
  int         jn;

  task automatic record();
    if (jn < 128) begin
      for (int k = 0; k < 3; k++) begin
        rec_tx[k][jn]   = tx_w[k];
        rec_busy[k][jn] = busy_w[k];
      end
      rec_cnt[jn] = cnt_w[0];
      rec_rdy[jn] = rdy_w[0];
    end
  endtask

  task automatic cap_start();
    @(negedge clk_in);
    jn = 0;
    record();
  endtask

  task automatic step();
    @(negedge clk_in);
    jn++;
    record();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < max_cycles) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_timeout", 64'(n < max_cycles), 64'd1);
    repeat (3) @(negedge clk_in);
  endtask

  initial begin : stim
    logic [9:0] pat;
    int busy_run, act;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    check("rst_tx",    64'(tx_w[0]),   64'd1);
    check("rst_busy",  64'(busy_w[0]), 64'd0);
    check("rst_count", 64'(cnt_w[0]),  64'd0);
    check("rst_ready", 64'(rdy_w[0]),  64'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);

    // Single 0x55 frame, 4-cycle bits.
    scaler = 32'd3;
    i_valid = 1'b1; i_data = 8'h55;
    cap_start();
    i_valid = 1'b0;
    repeat (41) step();
    pat = 10'b1010101010;
    check("t1_tx_before_start", 64'(rec_tx[0][0]), 64'd1);
    for (int j = 1; j <= 40; j++)
      check($sformatf("t1_bit_j%0d", j), 64'(rec_tx[0][j]), 64'(pat[(j-1)/4]));
    check("t1_busy_last", 64'(rec_busy[0][40]), 64'd1);
    check("t1_busy_drop", 64'(rec_busy[0][41]), 64'd0);
    check("t1_tx_idle",   64'(rec_tx[0][41]),   64'd1);
    wait_idle(200);

    // Three back-to-back frames, 2-cycle bits.
    scaler = 32'd1;
    i_valid = 1'b1; i_data = 8'h41;
    cap_start();
    i_data = 8'h42; step();
    i_data = 8'h0A; step();
    i_valid = 1'b0;
    repeat (60) step();
    busy_run = 0;
    for (int j = 1; j <= 60; j++) if (rec_busy[0][j]) busy_run++;
    check("t2_busy_cycles", 64'(busy_run), 64'd60);
    check("t2_busy_drop",   64'(rec_busy[0][61]), 64'd0);
    check("t2_start1", 64'(rec_tx[0][1]),  64'd0);
    check("t2_start2", 64'(rec_tx[0][21]), 64'd0);
    check("t2_start3", 64'(rec_tx[0][41]), 64'd0);
    check("t2_stop1",  64'(rec_tx[0][20]), 64'd1);
    check("t2_stop2",  64'(rec_tx[0][40]), 64'd1);
    check("t2_stop3",  64'(rec_tx[0][60]), 64'd1);
    wait_idle(200);

    // Overfill: 20 bytes offered continuously into a 16-deep FIFO.
    scaler = 32'd7;
    i_valid = 1'b1;
    for (int b = 0; b < 20; b++) begin
      i_data = 8'h80 + 8'(b);
      if (b == 0) cap_start();
      else        step();
    end
    i_valid = 1'b0;
    repeat (70) step();
    check("t3_count15", 64'(rec_cnt[15]), 64'd15);
    check("t3_ready15", 64'(rec_rdy[15]), 64'd1);
    check("t3_count16", 64'(rec_cnt[16]), 64'd16);
    check("t3_full",    64'(rec_rdy[16]), 64'd0);
    check("t3_full80",  64'(rec_cnt[80]), 64'd16);
    check("t3_pop81",   64'(rec_cnt[81]), 64'd15);
    check("t3_ready81", 64'(rec_rdy[81]), 64'd1);
    wait_idle(3000);

    // Parity placement for 0x07: even -> 1, odd -> 0.
    scaler = 32'd3;
    i_valid = 1'b1; i_data = 8'h07;
    cap_start();
    i_valid = 1'b0;
    repeat (50) step();
    check("t4_even_par", 64'(rec_tx[1][37]), 64'd1);
    check("t4_odd_par",  64'(rec_tx[2][37]), 64'd0);
    check("t4_odd_par_end", 64'(rec_tx[2][40]), 64'd0);
    check("t4_noparity_stop", 64'(rec_tx[0][37]), 64'd1);
    check("t4_bit7_even", 64'(rec_tx[1][36]), 64'd0);
    check("t4_even_busy48", 64'(rec_busy[1][48]), 64'd1);
    check("t4_even_busy49", 64'(rec_busy[1][49]), 64'd0);
    check("t4_odd_busy44",  64'(rec_busy[2][44]), 64'd1);
    check("t4_odd_busy45",  64'(rec_busy[2][45]), 64'd0);
    wait_idle(200);

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    i_valid = 1'b1; i_data = 8'hF0;
    cap_start();
    i_data = 8'h11; step();
    i_data = 8'h22; step();
    i_valid = 1'b0;
    repeat (15) step();
    check("t5_bit3",   64'(rec_tx[0][17]), 64'd0);
    check("t5_queued", 64'(rec_cnt[17]),   64'd2);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_tx",    64'(tx_w[0]),   64'd1);
    check("t5_rst_count", 64'(cnt_w[0]),  64'd0);
    check("t5_rst_busy",  64'(busy_w[0]), 64'd0);
    check("t5_rst_ready", 64'(rdy_w[0]),  64'd1);
    @(negedge clk_in);
    rst = 1'b0;
    act = 0;
    repeat (60) begin
      @(negedge clk_in);
      for (int k = 0; k < 3; k++) if (busy_w[k] || !tx_w[k]) act++;
    end
    check("t5_no_frames", 64'(act), 64'd0);

    // Scaler change mid-frame only affects the next frame.
    scaler = 32'd3;
    i_valid = 1'b1; i_data = 8'h0F;
    cap_start();
    i_data = 8'h3C; step();
    i_valid = 1'b0;
    repeat (8) step();
    scaler = 32'd9;
    repeat (70) step();
    check("t6_f1_bit7",  64'(rec_tx[0][36]), 64'd0);
    check("t6_f1_stop",  64'(rec_tx[0][37]), 64'd1);
    check("t6_f1_stop4", 64'(rec_tx[0][40]), 64'd1);
    check("t6_f2_start", 64'(rec_tx[0][41]), 64'd0);
    check("t6_f2_bit0",  64'(rec_tx[0][60]), 64'd0);
    check("t6_f2_bit1",  64'(rec_tx[0][70]), 64'd0);
    check("t6_f2_bit2",  64'(rec_tx[0][71]), 64'd1);
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
